// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg : shared types and constants for the valid/ready byte-handshake bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hs_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int          DATA_W_DEF    = 8;
  localparam int          LEN_W_DEF     = 8;
  localparam logic [7:0]  LFSR_SEED_DEF = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    lfsr8_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hs_lfsr8.sv
// ---------------------------------------------------------------------------
// hs_lfsr8 : 8-bit Galois LFSR with synchronous seed load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hs_lfsr8
  import hs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (enable) begin
      q <= lfsr8_next(q);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hs_burst_src.sv
// ---------------------------------------------------------------------------
// hs_burst_src : programmed-burst valid/ready source with optional LFSR bubbles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hs_burst_src
  import hs_pkg::*;
#(
  parameter int         DATA_W    = DATA_W_DEF,
  parameter int         LEN_W     = LEN_W_DEF,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic              bubble_en_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  sent_cnt_o,
  output logic              valid_post_o,
  output logic [DATA_W-1:0] data_post_o,
  input  logic              ready_post_i
);

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_rem, w_rem_nxt, w_rem_after;
  logic [LEN_W-1:0]    r_sent, w_sent_nxt;
  logic [DATA_W-1:0]   r_next, w_next_nxt;
  logic [DATA_W-1:0]   r_step, w_step_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic                r_bub, w_bub_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_done, w_done_nxt;
  logic [7:0]          w_lfsr;
  logic                w_xfer, w_start_ok, w_bubble;

  assign w_xfer     = r_valid && ready_post_i;
  assign w_start_ok = (r_state == IDLE) && start_i;
  // A healthy LFSR is never zero, so the reduction term only guards a stuck register
  assign w_bubble   = r_bub && w_lfsr[0] && (|w_lfsr);

  hs_lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (r_state == SEND),
    .load   (w_start_ok),
    .seed   (LFSR_SEED),
    .q      (w_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_sent_nxt  = r_sent;
    w_next_nxt  = r_next;
    w_step_nxt  = r_step;
    w_data_nxt  = r_data;
    w_bub_nxt   = r_bub;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_rem_after = r_rem - {{(LEN_W-1){1'b0}}, w_xfer};
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_sent_nxt = '0;
          if (len_i == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = SEND;
            w_rem_nxt   = len_i;
            w_step_nxt  = step_i;
            w_bub_nxt   = bubble_en_i;
            // The freshly seeded LFSR governs whether the first beat launches now
            if (!(bubble_en_i && LFSR_SEED[0])) begin
              w_valid_nxt = 1'b1;
              w_data_nxt  = base_i;
              w_next_nxt  = base_i + step_i;
            end else begin
              w_valid_nxt = 1'b0;
              w_next_nxt  = base_i;
            end
          end
        end
      end
      SEND: begin
        w_rem_nxt = w_rem_after;
        if (w_xfer) begin
          w_sent_nxt = r_sent + 1'b1;
        end
        if (w_xfer && (w_rem_after == '0)) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (!r_valid || w_xfer) begin
          w_valid_nxt = (w_rem_after != '0) && !w_bubble;
          if (w_valid_nxt) begin
            w_data_nxt = r_next;
            w_next_nxt = r_next + r_step;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_sent  <= '0;
      r_next  <= '0;
      r_step  <= '0;
      r_data  <= '0;
      r_bub   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_sent  <= w_sent_nxt;
      r_next  <= w_next_nxt;
      r_step  <= w_step_nxt;
      r_data  <= w_data_nxt;
      r_bub   <= w_bub_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy_o       = (r_state == SEND);
  assign done_o       = r_done;
  assign sent_cnt_o   = r_sent;
  assign valid_post_o = r_valid;
  assign data_post_o  = r_data;

endmodule

`default_nettype wire

// File: doc/hs_burst_src.md
Name: hs_burst_src

Overview:
- Transmitting end of the team's valid/ready byte-handshake bus.
- Generates a programmed burst of data beats toward a post-stage and obeys backpressure.
- Optionally inserts pseudo-random idle bubbles between beats.
- Drives any Handshake_TypeN stage or sink under test, and serves as a reusable traffic source in integration.

Parameters:
- DATA_W, 8, width of the data beat.
- LEN_W, 8, width of the burst-length field; max burst is 2^LEN_W-1 beats.
- LFSR_SEED, 8'hA5, non-zero reset/reload value of the bubble LFSR.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- start_i  in  1  Burst request; sampled only when busy_o==0.
- len_i  in  LEN_W  Beats in the burst; captured with start_i.
- base_i  in  DATA_W  First beat value; captured with start_i.
- step_i  in  DATA_W  Per-beat increment; captured with start_i.
- bubble_en_i  in  1  Enables LFSR bubble insertion; captured with start_i.
- busy_o  out  1  High from the accepted start until the burst completes.
- done_o  out  1  Single-cycle completion pulse.
- sent_cnt_o  out  LEN_W  Handshakes completed in the current or most recent burst.
- valid_post_o  out  1  Beat valid to the post-stage; registered.
- data_post_o  out  DATA_W  Beat data to the post-stage; registered.
- ready_post_i  in  1  Post-stage ready.

Behaviour:
- Reset (rst high at an edge):
  - busy_o, done_o, valid_post_o = 0; data_post_o = 0; sent_cnt_o = 0.
  - LFSR = LFSR_SEED; state = IDLE.
  - Mid-burst reset takes effect at that same edge; the partial burst is abandoned and done_o is not asserted.
- Handshake: a beat transfers in any cycle where valid_post_o && ready_post_i.
- Valid/data stability: once valid_post_o is high it stays high, and data_post_o stays stable, until the transfer. No retraction.
- ready_post_i may depend combinationally on anything; valid_post_o never depends combinationally on ready_post_i.
- States:
  - IDLE:
    - busy_o=0.
    - start_i=1 with len_i!=0: capture len/base/step/bubble_en, clear sent_cnt, go to SEND.
    - start_i=1 with len_i==0: clear sent_cnt, stay IDLE, pulse done_o next cycle; no beats issued.
  - SEND:
    - busy_o=1.
    - remaining counter loaded with len_i; next-data register loaded with base_i.
    - Valid-launch decision is made in any cycle where valid_post_o==0 or a transfer occurs (the "slot free" condition).
    - valid_post_o_next = (remaining_after_transfer != 0) && !(bubble_en && lfsr[0]).
    - When launching, data_post_o_next = next-data, and next-data += step_i (mod 2^DATA_W, wrap silently).
    - Each transfer: remaining -= 1, sent_cnt_o += 1.
    - Transfer of the last beat (remaining==1): valid_post_o drops at the next edge unless a new beat is launched (it cannot be); state goes to IDLE; done_o=1 for exactly the following cycle; busy_o falls in that same cycle.
- LFSR:
  - 8-bit Galois form, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle in SEND; reloaded with LFSR_SEED on accepted start.
  - Bubbles occur only while valid is low between beats; they never break a pending beat.
- Latency and throughput:
  - Accepted start in cycle N gives valid_post_o=1 in cycle N+1 when no bubble applies.
  - Throughput is 1 beat/cycle with ready held high and bubbles off.
- start_i while busy_o==1 is ignored; captured config does not change.
- start_i in the same cycle done_o is high is accepted, since state is already IDLE.

Decomposition:
- Package hs_pkg holds:
  - state enum {IDLE, SEND}
  - LFSR tap constant 8'hB8
  - LFSR_SEED default
  - DATA_W and LEN_W defaults
- Sub-module hs_lfsr8 (enable, load, seed, q), shared later by a matching random-ready sink.
- The FSM, counters and output registers stay in hs_burst_src.

Test Plan:
1. len=4, base=0x10, step=1, ready=1, bubbles off, start at cycle N:
   - valid_post_o high in N+1..N+4 with data 0x10, 0x11, 0x12, 0x13.
   - done_o=1 only in N+5; sent_cnt_o=4.
2. Same burst with ready_post_i=0 for cycles N+1..N+3:
   - valid_post_o stays 1 and data_post_o stays 0x10 through N+3.
   - 0x11 appears in N+5.
   - done_o in N+8.
3. len=0 start:
   - valid_post_o never rises.
   - busy_o stays 0.
   - done_o=1 in N+1; sent_cnt_o=0.
4. base=0xFE, step=1, len=3, ready=1:
   - beats 0xFE, 0xFF, 0x00 (wrap).
   - step=0x40, base=0xC0, len=2 gives 0xC0, 0x00.
5. Second start_i pulsed at N+2 of a len=4 burst:
   - burst unchanged, 4 beats, one done_o.
   - start_i pulsed coincident with done_o starts a new burst, with valid the next cycle.
6. Mid-burst rst at N+2, then bubble_en=1, len=8, ready=1:
   - Reset: valid_post_o=0, busy_o=0, sent_cnt_o=0 at N+3, and no done_o.
   - Bubble burst: exactly 8 transfers with data base..base+7 in order.
   - Idle gaps match a reference model of the LFSR seeded with 0xA5.
